// File: rtl/dp_result_pkg.sv
// Shared definitions for the result collector: field widths of the {z,x}
// pair, the bit offsets of each field inside a stored pair, and a helper
// that classifies a one-bit-wider signed sum as in range or clipped.
package dp_result_pkg;

  localparam int Z_W        = 8;
  localparam int X_W        = 16;
  localparam int PAIR_W     = Z_W + X_W;
  localparam int PAIR_X_LSB = 0;
  localparam int PAIR_Z_LSB = X_W;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  // A signed sum carried one bit wider than its destination overflowed
  // exactly when the top two bits disagree; the top bit gives the true sign.
  function automatic sat_e sat_check(input logic top_bit, input logic next_bit);
    if (top_bit == next_bit) begin
      return SAT_NONE;
    end else if (top_bit) begin
      return SAT_NEG;
    end else begin
      return SAT_POS;
    end
  endfunction

endpackage

// File: rtl/dp_pair_fifo.sv
// Small synchronous FIFO with a show-ahead head.
// Ports:
//   Clk, Rst    clock and synchronous active-high reset
//   push        write push_data this cycle (ignored when full without a pop)
//   push_data   WIDTH-bit entry
//   pop         remove the head (ignored when empty)
//   head_valid  FIFO holds at least one entry
//   head_data   current head, forced to zero when empty
//   count       occupancy, 0..DEPTH
// A freshly written entry becomes visible the cycle after the push; there is
// no write-to-read bypass.
module dp_pair_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    push_ok  = push && ((count_q != (AW+1)'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap.
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge Clk) begin
    if (push_ok && !Rst) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/dp_result_collector.sv
// Downstream collector for the Circuit1 datapath.
// Realigns the same-cycle z result with the one-cycle-later x result into a
// {z,x} pair, queues pairs in a DEPTH-entry FIFO and presents them on a
// valid/ready output. Also keeps a saturating signed running sum of every
// drained x value.
// Ports:
//   Clk, Rst           clock and synchronous active-high reset
//   in_valid/in_ready  sample issue handshake (in_ready is credit based)
//   z_in               signed z, same cycle as in_valid
//   x_in               signed x, the cycle after in_valid
//   out_valid/out_ready/out_z/out_x  FIFO head handshake and data
//   count              FIFO occupancy
//   acc_clr            clear running sum and its saturation flag
//   acc_x, acc_sat     running sum of popped x and sticky clip flag
//   ovf                sticky: a sample was offered while in_ready was low
module dp_result_collector
  import dp_result_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 24
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [Z_W-1:0]          z_in,
  input  logic [X_W-1:0]          x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [Z_W-1:0]          out_z,
  output logic [X_W-1:0]          out_x,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    acc_clr,
  output logic [ACC_W-1:0]        acc_x,
  output logic                    acc_sat,
  output logic                    ovf
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             v_q, v_d;
  logic [Z_W-1:0]   z_q, z_d;
  logic [ACC_W-1:0] acc_x_q, acc_x_d;
  logic             acc_sat_q, acc_sat_d;
  logic             ovf_q, ovf_d;

  logic [PAIR_W-1:0] push_pair;
  logic [PAIR_W-1:0] head_pair;
  logic              head_valid;
  logic              pop;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     credit_used;
  logic [ACC_W:0]    sum_w;
  logic [X_W-1:0]    head_x;
  logic [Z_W-1:0]    head_z;

  dp_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk        (Clk),
    .Rst        (Rst),
    .push       (v_q),
    .push_data  (push_pair),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_pair),
    .count      (fifo_count)
  );

  always_comb begin
    head_z = head_pair[PAIR_Z_LSB +: Z_W];
    head_x = head_pair[PAIR_X_LSB +: X_W];

    push_pair = '0;
    push_pair[PAIR_Z_LSB +: Z_W] = z_q;
    push_pair[PAIR_X_LSB +: X_W] = x_in;

    // A sample in flight in the align register already owns a FIFO slot, so
    // counting it here means the push one cycle later can never find it full.
    credit_used = fifo_count + CW'(v_q);
    in_ready    = (credit_used < CW'(DEPTH));

    pop = head_valid && out_ready;

    v_d   = in_valid && in_ready;
    z_d   = z_in;
    ovf_d = ovf_q || (in_valid && !in_ready);

    // Sum one bit wider than the accumulator so a single add cannot wrap.
    sum_w = {acc_x_q[ACC_W-1], acc_x_q}
          + {{(ACC_W + 1 - X_W){head_x[X_W-1]}}, head_x};

    acc_x_d   = acc_x_q;
    acc_sat_d = acc_sat_q;
    if (acc_clr) begin
      acc_x_d   = '0;
      acc_sat_d = 1'b0;
    end else if (pop) begin
      case (sat_check(sum_w[ACC_W], sum_w[ACC_W-1]))
        SAT_POS: begin
          acc_x_d   = {1'b0, {(ACC_W-1){1'b1}}};
          acc_sat_d = 1'b1;
        end
        SAT_NEG: begin
          acc_x_d   = {1'b1, {(ACC_W-1){1'b0}}};
          acc_sat_d = 1'b1;
        end
        default: acc_x_d = sum_w[ACC_W-1:0];
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      v_q       <= 1'b0;
      z_q       <= '0;
      acc_x_q   <= '0;
      acc_sat_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      v_q       <= v_d;
      z_q       <= z_d;
      acc_x_q   <= acc_x_d;
      acc_sat_q <= acc_sat_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = head_valid;
  assign out_z     = head_z;
  assign out_x     = head_x;
  assign count     = fifo_count;
  assign acc_x     = acc_x_q;
  assign acc_sat   = acc_sat_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dp_result_collector.sv
// Bench for dp_result_collector: two instances share all inputs, one with the
// default 24-bit accumulator and one with a 17-bit accumulator so clipping is
// reachable. A queue-based reference model tracks pairs, credit and sums.
module tb_dp_result_collector;

  localparam int DEPTH = 4;
  localparam int ACC_A = 24;
  localparam int ACC_B = 17;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        in_valid;
  logic        out_ready;
  logic        acc_clr;
  logic [7:0]  z_in;
  logic [15:0] x_in;

  logic             a_in_ready, a_out_valid, a_acc_sat, a_ovf;
  logic [7:0]       a_out_z;
  logic [15:0]      a_out_x;
  logic [2:0]       a_count;
  logic [ACC_A-1:0] a_acc_x;

  logic             b_in_ready, b_out_valid, b_acc_sat, b_ovf;
  logic [7:0]       b_out_z;
  logic [15:0]      b_out_x;
  logic [2:0]       b_count;
  logic [ACC_B-1:0] b_acc_x;

  always #5 Clk = ~Clk;

  dp_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_A)) dut_a (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .z_in(z_in), .x_in(x_in), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_z(a_out_z), .out_x(a_out_x), .count(a_count), .acc_clr(acc_clr),
    .acc_x(a_acc_x), .acc_sat(a_acc_sat), .ovf(a_ovf)
  );

  dp_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_B)) dut_b (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .z_in(z_in), .x_in(x_in), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_z(b_out_z), .out_x(b_out_x), .count(b_count), .acc_clr(acc_clr),
    .acc_x(b_acc_x), .acc_sat(b_acc_sat), .ovf(b_ovf)
  );

  // ---------------- reference model ----------------
  typedef struct { int z; int x; } pair_t;
  pair_t  mq[$];
  bit     m_pend;
  int     m_pend_z;
  longint m_acc_a, m_acc_b;
  bit     m_sat_a, m_sat_b, m_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic longint clip(longint s, int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic check_model();
    int hz, hx;
    bit rdy;
    hz  = 0;
    hx  = 0;
    if (mq.size() > 0) begin
      hz = mq[0].z;
      hx = mq[0].x;
    end
    rdy = (mq.size() + int'(m_pend)) < DEPTH;
    chk("model.in_ready",  a_in_ready, rdy);
    chk("model.out_valid", a_out_valid, mq.size() > 0);
    chk("model.count",     a_count, mq.size());
    chk("model.out_z",     $signed(a_out_z), hz);
    chk("model.out_x",     $signed(a_out_x), hx);
    chk("model.acc_a",     $signed(a_acc_x), m_acc_a);
    chk("model.sat_a",     a_acc_sat, m_sat_a);
    chk("model.ovf",       a_ovf, m_ovf);
    chk("model.b_count",   b_count, mq.size());
    chk("model.b_out_x",   $signed(b_out_x), hx);
    chk("model.acc_b",     $signed(b_acc_x), m_acc_b);
    chk("model.sat_b",     b_acc_sat, m_sat_b);
    chk("model.b_ready",   b_in_ready, rdy);
    chk("model.b_ovf",     b_ovf, m_ovf);
    chk("model.b_valid",   b_out_valid, mq.size() > 0);
    chk("model.b_out_z",   $signed(b_out_z), hz);
  endtask

  // Advances the model by the clock edge about to happen, using current inputs.
  task automatic model_update();
    bit     rdy, popping;
    longint s;
    pair_t  p;
    if (Rst) begin
      mq.delete();
      m_pend = 0; m_pend_z = 0;
      m_acc_a = 0; m_acc_b = 0;
      m_sat_a = 0; m_sat_b = 0; m_ovf = 0;
    end else begin
      rdy     = (mq.size() + int'(m_pend)) < DEPTH;
      popping = (mq.size() > 0) && out_ready;
      if (acc_clr) begin
        m_acc_a = 0; m_acc_b = 0; m_sat_a = 0; m_sat_b = 0;
      end else if (popping) begin
        s = m_acc_a + mq[0].x;
        m_acc_a = clip(s, ACC_A);
        if (m_acc_a != s) m_sat_a = 1;
        s = m_acc_b + mq[0].x;
        m_acc_b = clip(s, ACC_B);
        if (m_acc_b != s) m_sat_b = 1;
      end
      if (popping) void'(mq.pop_front());
      if (m_pend) begin
        p.z = m_pend_z;
        p.x = int'($signed(x_in));
        mq.push_back(p);
      end
      if (in_valid && !rdy) m_ovf = 1;
      m_pend   = in_valid && rdy;
      m_pend_z = int'($signed(z_in));
    end
  endtask

  task automatic to_neg();
    @(negedge Clk);
    if (chk_en) check_model();
  endtask

  task automatic finish_cycle();
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic cycle();
    to_neg();
    finish_cycle();
  endtask

  task automatic drive(bit iv, int z, int x, bit ordy, bit clr);
    in_valid  = iv;
    z_in      = 8'(z);
    x_in      = 16'(x);
    out_ready = ordy;
    acc_clr   = clr;
  endtask

  // ---------------- fill/drain vector table ----------------
  typedef struct {
    bit iv; int z; int x; bit ordy;
    bit e_rdy; bit e_ov; int e_z; int e_x; int e_cnt; bit e_ovf;
  } vec_t;
  vec_t tab[11];

  initial begin
    tab[0]  = '{1, 10, 0,    0, 1, 0, 0,  0,    0, 0};
    tab[1]  = '{1, 11, 1000, 0, 1, 0, 0,  0,    0, 0};
    tab[2]  = '{1, 12, 1001, 0, 1, 1, 10, 1000, 1, 0};
    tab[3]  = '{1, 13, 1002, 0, 1, 1, 10, 1000, 2, 0};
    tab[4]  = '{1, 14, 1003, 0, 0, 1, 10, 1000, 3, 0};
    tab[5]  = '{1, 15, 0,    0, 0, 1, 10, 1000, 4, 1};
    tab[6]  = '{0, 0,  0,    1, 0, 1, 10, 1000, 4, 1};
    tab[7]  = '{0, 0,  0,    1, 1, 1, 11, 1001, 3, 1};
    tab[8]  = '{0, 0,  0,    1, 1, 1, 12, 1002, 2, 1};
    tab[9]  = '{0, 0,  0,    1, 1, 1, 13, 1003, 1, 1};
    tab[10] = '{0, 0,  0,    0, 1, 0, 0,  0,    0, 1};

    // ---- reset for two cycles ----
    Rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    cycle();
    chk_en = 1;
    cycle();
    Rst = 1'b0;
    to_neg();
    chk("reset.out_valid", a_out_valid, 0);
    chk("reset.count",     a_count, 0);
    chk("reset.acc_x",     $signed(a_acc_x), 0);
    chk("reset.in_ready",  a_in_ready, 1);
    chk("reset.ovf",       a_ovf, 0);
    chk("reset.acc_sat",   a_acc_sat, 0);
    finish_cycle();

    // ---- single sample latency ----
    drive(1, -3, 0, 1, 0);
    to_neg(); chk("lat.n0.out_valid", a_out_valid, 0); finish_cycle();
    drive(0, 0, 1000, 1, 0);
    to_neg(); chk("lat.n1.out_valid", a_out_valid, 0); finish_cycle();
    drive(0, 0, 0, 1, 0);
    to_neg();
    chk("lat.n2.out_valid", a_out_valid, 1);
    chk("lat.n2.out_z",     $signed(a_out_z), -3);
    chk("lat.n2.out_x",     $signed(a_out_x), 1000);
    finish_cycle();
    to_neg();
    chk("lat.n3.acc_x", $signed(a_acc_x), 1000);
    chk("lat.n3.count", a_count, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 1);
    cycle();

    // ---- fill to credit limit, overflow, ordered drain ----
    for (int i = 0; i < 11; i++) begin
      drive(tab[i].iv, tab[i].z, tab[i].x, tab[i].ordy, 0);
      to_neg();
      chk($sformatf("fill[%0d].in_ready", i),  a_in_ready, tab[i].e_rdy);
      chk($sformatf("fill[%0d].out_valid", i), a_out_valid, tab[i].e_ov);
      chk($sformatf("fill[%0d].out_z", i),     $signed(a_out_z), tab[i].e_z);
      chk($sformatf("fill[%0d].out_x", i),     $signed(a_out_x), tab[i].e_x);
      chk($sformatf("fill[%0d].count", i),     a_count, tab[i].e_cnt);
      chk($sformatf("fill[%0d].ovf", i),       a_ovf, tab[i].e_ovf);
      finish_cycle();
    end
    to_neg();
    chk("fill.acc_x", $signed(a_acc_x), 4006);
    finish_cycle();

    // ---- steady count=2 with push+pop every cycle across pointer wrap ----
    drive(1, 20, 0, 0, 0);    cycle();
    drive(1, 21, 2000, 0, 0); cycle();
    drive(0, 0, 2001, 0, 0);  cycle();
    drive(1, 22, 0, 0, 0);    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1, 23 + i, int'($urandom_range(0, 65535)), 1, 0);
      to_neg();
      chk($sformatf("steady[%0d].count", i), a_count, 2);
      finish_cycle();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, int'($urandom_range(0, 65535)), 1, 0);
      cycle();
    end

    // ---- saturation on the 17-bit accumulator, then clear during a pop ----
    drive(0, 0, 0, 1, 1); cycle();
    drive(1, 1, 0, 1, 0);     cycle();
    drive(1, 2, 32767, 1, 0); cycle();
    drive(1, 3, 32767, 1, 0); cycle();
    drive(0, 0, 32767, 1, 0); cycle();
    drive(0, 0, 0, 1, 0);     cycle();
    drive(0, 0, 0, 1, 0);
    to_neg();
    chk("sat.acc_b", $signed(b_acc_x), 65535);
    chk("sat.sat_b", b_acc_sat, 1);
    chk("sat.acc_a", $signed(a_acc_x), 98301);
    chk("sat.sat_a", a_acc_sat, 0);
    finish_cycle();
    drive(1, 4, 0, 1, 0); cycle();
    drive(0, 0, 5, 1, 0); cycle();
    drive(0, 0, 0, 1, 1);
    to_neg(); chk("clrpop.out_valid", a_out_valid, 1); finish_cycle();
    drive(0, 0, 0, 1, 0);
    to_neg();
    chk("clrpop.acc_b", $signed(b_acc_x), 0);
    chk("clrpop.sat_b", b_acc_sat, 0);
    chk("clrpop.acc_a", $signed(a_acc_x), 0);
    chk("clrpop.count", a_count, 0);
    finish_cycle();

    // ---- reset mid-stream with count=3 and a sample in flight ----
    for (int i = 0; i < 4; i++) begin
      drive(1, 40 + i, 3000 + i, 0, 0);
      cycle();
    end
    drive(0, 0, 3004, 0, 0);
    Rst = 1'b1;
    to_neg(); chk("rst_mid.count_before", a_count, 3); finish_cycle();
    Rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    to_neg();
    chk("rst_mid.count",     a_count, 0);
    chk("rst_mid.out_valid", a_out_valid, 0);
    chk("rst_mid.ovf",       a_ovf, 0);
    finish_cycle();
    to_neg(); chk("rst_mid.no_late_push", a_count, 0); finish_cycle();

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) < 60,
            int'($urandom_range(0, 255)),
            int'($urandom_range(0, 65535)),
            $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 3);
      Rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    Rst = 1'b0;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
